// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : RV32I integer ALU. Combinational result/zero for branch
//             resolution and writeback, plus a registered copy with valid
//             for pipelined consumers.
//  Revision : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  input  logic            in_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q,
  output logic            out_valid
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;

  // Only the low five bits of b form the shift amount; the rest are ignored.
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_zero;
  logic [XLEN-1:0] result_d;
  logic            zero_d;
  logic            out_valid_d;
  logic            out_valid_q;

  assign w_shamt = b[4:0];

  // Operation select; reserved opcodes fall through to zero.
  always_comb begin
    w_result = '0;
    unique case (alu_control)
      OP_ADD:  w_result = a + b;
      OP_SUB:  w_result = a - b;
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_XOR:  w_result = a ^ b;
      OP_SLL:  w_result = a << w_shamt;
      OP_SRL:  w_result = a >> w_shamt;
      OP_SRA:  w_result = $signed(a) >>> w_shamt;
      // True signed compare: immune to the overflow that a - b would suffer.
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_LUI:  w_result = b;
      default: w_result = '0;
    endcase
  end

  assign w_zero = (w_result == '0);
  assign result = w_result;
  assign zero   = w_zero;

  // Next state for the output register: capture on in_valid, otherwise hold.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = w_result;
      zero_d      = w_zero;
      out_valid_d = 1'b1;
    end
  end

  // Output register; reset takes priority over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Self-checking bench for alu: directed vector table, directed
//             register-stage sequences, and random stimulus against a
//             behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic        out_valid;

  int n_vec;
  int n_err;

  alu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .in_valid    (in_valid),
    .result      (result),
    .zero        (zero),
    .result_q    (result_q),
    .zero_q      (zero_q),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_r;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on wide integers.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    longint      ux, uy;
    longint      p2;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    sh = int'(y % 32);
    p2 = longint'(1) << sh;
    case (op)
      4'd0:  return 32'((ux + uy) % (longint'(1) << 32));
      4'd1:  return 32'((ux - uy + (longint'(1) << 32)) % (longint'(1) << 32));
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return 32'((ux * p2) % (longint'(1) << 32));
      4'd6:  return 32'(ux / p2);
      // Floor division by 2^sh for the arithmetic shift.
      4'd7:  return (sx >= 0) ? 32'(sx / p2) : 32'(-((-sx + p2 - 1) / p2));
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (ux < uy) ? 32'd1 : 32'd0;
      4'd10: return y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_rq;
  logic        exp_zq;
  logic [31:0] r_ref;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    alu_control = '0;

    vecs.push_back('{4'd0,  32'd10,         32'd5,          32'd15,         1'b0});
    vecs.push_back('{4'd1,  32'd10,         32'd10,         32'd0,          1'b1});
    vecs.push_back('{4'd0,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1});
    vecs.push_back('{4'd2,  32'hF0,         32'h0F,         32'd0,          1'b1});
    vecs.push_back('{4'd3,  32'hF0,         32'h0F,         32'hFF,         1'b0});
    vecs.push_back('{4'd4,  32'hF0,         32'h0F,         32'hFF,         1'b0});
    vecs.push_back('{4'd10, 32'd0,          32'hDEADBEEF,   32'hDEADBEEF,   1'b0});
    vecs.push_back('{4'd5,  32'd1,          32'd5,          32'h20,         1'b0});
    vecs.push_back('{4'd6,  32'h80000000,   32'd31,         32'h1,          1'b0});
    vecs.push_back('{4'd7,  32'h80000000,   32'd31,         32'hFFFFFFFF,   1'b0});
    vecs.push_back('{4'd5,  32'd1,          32'h25,         32'h20,         1'b0});
    vecs.push_back('{4'd8,  32'hFFFFFFFB,   32'd3,          32'd1,          1'b0});
    vecs.push_back('{4'd8,  32'd3,          32'hFFFFFFFB,   32'd0,          1'b1});
    vecs.push_back('{4'd9,  32'd3,          32'd5,          32'd1,          1'b0});
    vecs.push_back('{4'd9,  32'd5,          32'd3,          32'd0,          1'b1});
    vecs.push_back('{4'd9,  32'hFFFFFFFB,   32'd3,          32'd0,          1'b1});
    vecs.push_back('{4'd15, 32'd7,          32'd9,          32'd0,          1'b1});
    vecs.push_back('{4'd8,  32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0});
    vecs.push_back('{4'd1,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0});
    vecs.push_back('{4'd11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b1});

    // Directed combinational table (reset held; result must not care).
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      alu_control = vecs[i].op;
      a = vecs[i].va;
      b = vecs[i].vb;
      #1;
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_r);
      check($sformatf("vec%0d_zero", i), {31'h0, zero}, {31'h0, vecs[i].exp_z});
    end

    // Reset held for two edges.
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_result_q", result_q, 32'd0);
    check("rst_zero_q", {31'h0, zero_q}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);

    // Release, issue ADD 2+3.
    rst_n = 1'b1;
    in_valid = 1'b1;
    alu_control = 4'd0;
    a = 32'd2;
    b = 32'd3;
    tick();
    check("add_result_q", result_q, 32'd5);
    check("add_zero_q", {31'h0, zero_q}, 32'd0);
    check("add_out_valid", {31'h0, out_valid}, 32'd1);

    // Idle: hold result_q, drop valid.
    in_valid = 1'b0;
    a = 32'd100;
    b = 32'd100;
    alu_control = 4'd1;
    tick();
    check("hold_result_q", result_q, 32'd5);
    check("hold_zero_q", {31'h0, zero_q}, 32'd0);
    check("hold_out_valid", {31'h0, out_valid}, 32'd0);

    // Back-to-back valid: SUB 4-4 then ADD 1+1.
    in_valid = 1'b1;
    alu_control = 4'd1;
    a = 32'd4;
    b = 32'd4;
    tick();
    check("b2b0_result_q", result_q, 32'd0);
    check("b2b0_zero_q", {31'h0, zero_q}, 32'd1);
    check("b2b0_out_valid", {31'h0, out_valid}, 32'd1);
    alu_control = 4'd0;
    a = 32'd1;
    b = 32'd1;
    tick();
    check("b2b1_result_q", result_q, 32'd2);
    check("b2b1_zero_q", {31'h0, zero_q}, 32'd0);
    check("b2b1_out_valid", {31'h0, out_valid}, 32'd1);

    // Reset together with in_valid: reset wins; comb path still live.
    rst_n = 1'b0;
    a = 32'd7;
    b = 32'd9;
    #1;
    check("rst_comb_result", result, 32'd16);
    tick();
    check("rstv_result_q", result_q, 32'd0);
    check("rstv_zero_q", {31'h0, zero_q}, 32'd0);
    check("rstv_out_valid", {31'h0, out_valid}, 32'd0);

    // Random stimulus against the reference model, register stage included.
    rst_n = 1'b1;
    exp_rq = 32'd0;
    exp_zq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      alu_control = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'h80000000 ^ 32'($urandom_range(0, 3));
        2: a = 32'($urandom_range(0, 8));
        default: a = 32'hFFFFFFFF - 32'($urandom_range(0, 8));
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
        2: b = 32'($urandom_range(0, 40));
        default: b = a;
      endcase
      in_valid = 1'($urandom_range(0, 1));
      #1;
      r_ref = ref_alu(alu_control, a, b);
      check($sformatf("rnd%0d_op%0d_result", i, alu_control), result, r_ref);
      check($sformatf("rnd%0d_zero", i), {31'h0, zero}, {31'h0, (r_ref == 32'd0)});
      if (in_valid) begin
        exp_rq = r_ref;
        exp_zq = (r_ref == 32'd0);
      end
      tick();
      check($sformatf("rnd%0d_result_q", i), result_q, exp_rq);
      check($sformatf("rnd%0d_zero_q", i), {31'h0, zero_q}, {31'h0, exp_zq});
      check($sformatf("rnd%0d_out_valid", i), {31'h0, out_valid}, {31'h0, in_valid});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- 32-bit RV32I integer ALU for the core's execute stage.
- Computes arithmetic, logic, shift, compare and LUI pass-through results from a 4-bit operation code.
- Result and zero flag are available combinationally in the same cycle, for branch resolution and writeback muxing.
- A registered copy of result and zero, with a valid flag, is provided for pipelined consumers.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a  input  32  operand A (rs1 / PC).
- b  input  32  operand B (rs2 / immediate); shift amount is taken from b[4:0].
- alu_control  input  4  operation select.
- in_valid  input  1  qualifies a/b/alu_control for the registered output stage.
- result  output  32  combinational result.
- zero  output  1  combinational flag, 1 when result == 0.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero flag.
- out_valid  output  1  registered in_valid.

Behaviour:
- result is purely combinational from a, b and alu_control; it is independent of clk and rst_n, with no latency.
- Operation codes:
  - 0000 ADD: a + b, modulo 2^32, carry discarded.
  - 0001 SUB: a - b, modulo 2^32.
  - 0010 AND: a & b.
  - 0011 OR: a | b.
  - 0100 XOR: a ^ b.
  - 0101 SLL: a << b[4:0]; b[31:5] ignored.
  - 0110 SRL: logical right shift of a by b[4:0], zero-filled.
  - 0111 SRA: arithmetic right shift of a by b[4:0], filled with a[31].
  - 1000 SLT: 1 if signed(a) < signed(b), else 0; upper 31 bits are 0.
  - 1001 SLTU: 1 if unsigned(a) < unsigned(b), else 0.
  - 1010 LUI: result = b (a ignored).
  - 1011–1111: reserved; result = 0, hence zero = 1.
- zero = 1 exactly when result == 32'h0, for every opcode, including SLT/SLTU returning 0.
- No overflow or carry flags. Overflow wraps silently; SLT uses a true signed compare, not the sign of a - b.
- Registered stage, on the rising edge of clk:
  - if rst_n == 0: result_q = 0, zero_q = 0, out_valid = 0 (reset dominates in_valid);
  - else if in_valid == 1: result_q = result, zero_q = zero, out_valid = 1;
  - else: result_q and zero_q hold, out_valid = 0.
- Registered-stage latency is 1 cycle from in_valid. Back-to-back in_valid cycles give back-to-back out_valid.
- Reset asserted mid-stream clears the registered outputs at the next edge. The combinational outputs are unaffected by reset.
- No X propagation on defined inputs. Every opcode, including reserved ones, yields a defined result.

Test Plan:
- ADD 10+5 -> result 15, zero 0. SUB 10-10 -> result 0, zero 1. ADD FFFFFFFF+1 -> result 0, zero 1 (wrap).
- AND F0,0F -> 0, zero 1. OR F0,0F -> FF. XOR F0,0F -> FF. LUI a=0, b=DEADBEEF -> DEADBEEF, zero 0.
- SLL 1 by 5 -> 00000020. SRL 80000000 by 31 -> 00000001. SRA 80000000 by 31 -> FFFFFFFF. SLL 1 with b=0x25 -> 00000020 (only b[4:0] used).
- SLT -5,3 -> 1, zero 0. SLT 3,-5 -> 0, zero 1. SLTU 3,5 -> 1. SLTU 5,3 -> 0, zero 1. SLTU FFFFFFFB,3 -> 0.
- Reserved opcode 1111, a=7, b=9 -> result 0, zero 1.
- Registered stage:
  - rst_n = 0 for 2 cycles -> result_q 0, zero_q 0, out_valid 0.
  - Release reset, then in_valid=1 with ADD 2+3 -> next edge: result_q 5, out_valid 1.
  - in_valid=0 -> result_q holds 5, out_valid 0.
  - Assert rst_n=0 together with in_valid=1 -> result_q clears to 0.
